// File: rtl/bpsk_pkg.sv
// Shared BPSK definitions: default stream geometry, accumulator sizing
// and the demodulator state encoding.
package bpsk_pkg;

    localparam int DEF_SAMPLE_NUMBER = 256;
    localparam int DEF_SAMPLE_WIDTH  = 12;
    localparam int DEF_DATA_WIDTH    = 12;

    typedef enum logic {
        IDLE,
        ACQ
    } state_t;

    // One period of full-scale samples plus a sign bit cannot overflow.
    function automatic int acc_width(input int n, input int w);
        return w + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/bpsk_correlator.sv
// Integrate-and-dump against the carrier sign; decides one bit per period.
// A clear restarts the period with the current sample taken as k=0.
module bpsk_correlator
    import bpsk_pkg::*;
#(
    parameter int SAMPLE_NUMBER = DEF_SAMPLE_NUMBER,
    parameter int SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
    parameter int THRESHOLD     = 4096
) (
    input  logic                           clk,
    input  logic                           arst,
    input  logic                           i_en,
    input  logic                           i_clear,
    input  logic signed [SAMPLE_WIDTH-1:0] i_sample,
    output logic                           o_bit,
    output logic                           o_weak,
    output logic                           o_done
);

    localparam int KW = $clog2(SAMPLE_NUMBER);
    localparam int AW = acc_width(SAMPLE_NUMBER, SAMPLE_WIDTH);

    logic        [KW-1:0] r_k;
    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] w_ext;
    logic signed [AW-1:0] w_base;
    logic signed [AW-1:0] w_next;
    logic        [AW-1:0] w_abs;

    always_comb begin
        w_ext  = {{(AW-SAMPLE_WIDTH){i_sample[SAMPLE_WIDTH-1]}}, i_sample};
        w_base = i_clear ? '0 : r_acc;
        // First half of the period correlates with +1, second half with -1.
        if (i_clear || !r_k[KW-1]) begin
            w_next = w_base + w_ext;
        end else begin
            w_next = w_base - w_ext;
        end
        w_abs = w_next[AW-1] ? -w_next : w_next;
    end

    assign o_done = i_en & ~i_clear & (&r_k);
    assign o_bit  = ~w_next[AW-1] & (|w_next);
    assign o_weak = w_abs < AW'(THRESHOLD);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_k   <= '0;
            r_acc <= '0;
        end else if (i_en) begin
            if (i_clear) begin
                r_k   <= KW'(1);
                r_acc <= w_next;
            end else begin
                r_k   <= r_k + KW'(1);
                r_acc <= o_done ? '0 : w_next;
            end
        end
    end

endmodule

// File: rtl/bpsk_demodulator.sv
// Coherent BPSK receiver: frames correlator bit decisions into a codeword,
// handling start-of-frame, mid-frame restarts and confidence tracking.
module bpsk_demodulator
    import bpsk_pkg::*;
#(
    parameter int SAMPLE_NUMBER = DEF_SAMPLE_NUMBER,
    parameter int SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int THRESHOLD     = 4096
) (
    input  logic                           clk,
    input  logic                           arst,
    input  logic                           en,
    input  logic                           sof,
    input  logic signed [SAMPLE_WIDTH-1:0] sample,
    output logic        [DATA_WIDTH-1:0]   q,
    output logic                           dv,
    output logic                           low_conf,
    output logic                           err
);

    localparam int CW = $clog2(DATA_WIDTH);

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-2:0] r_sr;
    logic                  r_weak;

    logic                  w_sof;
    logic                  w_cen;
    logic                  w_bit;
    logic                  w_weak;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_sof  = en & sof;
    assign w_cen  = en & (sof | (r_state == ACQ));
    assign w_word = {r_sr, w_bit};

    bpsk_correlator #(
        .SAMPLE_NUMBER(SAMPLE_NUMBER),
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .THRESHOLD    (THRESHOLD)
    ) u_corr (
        .clk     (clk),
        .arst    (arst),
        .i_en    (w_cen),
        .i_clear (w_sof),
        .i_sample(sample),
        .o_bit   (w_bit),
        .o_weak  (w_weak),
        .o_done  (w_done)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_sr     <= '0;
            r_weak   <= 1'b0;
            q        <= '0;
            dv       <= 1'b0;
            low_conf <= 1'b0;
            err      <= 1'b0;
        end else begin
            dv  <= 1'b0;
            err <= 1'b0;
            // A qualified sof always restarts; it only counts as an error mid-frame.
            if (w_sof) begin
                err     <= (r_state == ACQ);
                r_state <= ACQ;
                r_cnt   <= '0;
                r_sr    <= '0;
                r_weak  <= 1'b0;
            end else if (w_done) begin
                r_sr   <= w_word[DATA_WIDTH-2:0];
                r_weak <= r_weak | w_weak;
                if (r_cnt == CW'(DATA_WIDTH-1)) begin
                    r_state  <= IDLE;
                    r_cnt    <= '0;
                    q        <= w_word;
                    low_conf <= r_weak | w_weak;
                    dv       <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Scoreboard bench for bpsk_demodulator: stimulus pushes reference results,
// an independent monitor checks dv/err pulses as they appear.
module tb_bpsk_demodulator;

    localparam int N     = 256;
    localparam int DW    = 12;
    localparam int FRAME = N * DW;
    localparam int THR   = 4096;

    logic               clk = 1'b0;
    logic               arst = 1'b1;
    logic               en = 1'b0;
    logic               sof = 1'b0;
    logic signed [11:0] sample = '0;
    logic [DW-1:0]      q;
    logic               dv;
    logic               low_conf;
    logic               err;

    typedef struct {
        logic [DW-1:0] word;
        bit            lc;
        int            at;
    } exp_t;

    exp_t exp_q[$];
    int   err_q[$];
    int   smp[FRAME];
    int   edges = 0;
    int   errors = 0;
    int   checks = 0;
    bit   inframe = 1'b0;

    bpsk_demodulator dut (
        .clk     (clk),
        .arst    (arst),
        .en      (en),
        .sof     (sof),
        .sample  (sample),
        .q       (q),
        .dv      (dv),
        .low_conf(low_conf),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int sinv(input int k, input int amp);
        real r;
        r = amp * $sin(2.0 * 3.14159265358979 * k / N);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    task automatic build(input logic [DW-1:0] word, input int amp, input int nz);
        int s;
        for (int b = 0; b < DW; b++) begin
            for (int k = 0; k < N; k++) begin
                s = sinv(k, amp) * (word[DW-1-b] ? 1 : -1);
                if (nz > 0) s += int'($urandom_range(0, 2 * nz)) - nz;
                if (s > 2047) s = 2047;
                if (s < -2048) s = -2048;
                smp[b*N+k] = s;
            end
        end
    endtask

    // Reference: correlate each period against the carrier sign.
    task automatic model(output logic [DW-1:0] word, output bit lc);
        longint acc;
        word = '0;
        lc   = 1'b0;
        for (int b = 0; b < DW; b++) begin
            acc = 0;
            for (int k = 0; k < N; k++)
                acc += (k < N / 2) ? smp[b*N+k] : -smp[b*N+k];
            word = {word[DW-2:0], acc > 0};
            if ((acc < 0 ? -acc : acc) < THR) lc = 1'b1;
        end
    endtask

    task automatic send(input int start, input int n, input bit gapped);
        exp_t e;
        for (int i = start; i < start + n; i++) begin
            @(negedge clk);
            if (gapped && i > start) begin
                en = 1'b0;
                @(negedge clk);
            end
            en     = 1'b1;
            sample = 12'(smp[i]);
            sof    = (i == 0);
            if (i == 0) begin
                if (inframe) err_q.push_back(edges + 1);
                inframe = 1'b1;
            end
            if (i == FRAME - 1 && inframe) begin
                model(e.word, e.lc);
                e.at = edges + 1;
                exp_q.push_back(e);
                inframe = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en  = 1'b0;
            sof = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_q"}, q, 0);
        check({tag, "_dv"}, dv, 0);
        check({tag, "_lc"}, low_conf, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (dv && err) check("dv_err_overlap", 1, 0);
            if (dv) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_dv", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("q", q, e.word);
                    check("low_conf", low_conf, e.lc);
                    check("dv_time", edges, e.at);
                end
            end
            if (err) begin
                if (err_q.size() == 0) check("unexpected_err", 1, 0);
                else check("err_time", edges, err_q.pop_front());
            end
        end
    end

    initial begin
        logic [DW-1:0] w;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        arst = 1'b0;
        idle(3);

        build(12'hA5C, 2047, 0);
        send(0, FRAME, 1'b0);
        idle(5);
        send(0, FRAME, 1'b1);
        idle(5);

        build(12'h3F0, 1000, 600);
        send(0, FRAME, 1'b0);
        idle(4);

        build(12'h000, 0, 0);
        send(0, FRAME, 1'b0);
        idle(4);

        build(12'h555, 2047, 0);
        send(0, 1000, 1'b0);
        build(12'hAAA, 2047, 0);
        send(0, FRAME, 1'b0);
        idle(4);

        build(12'h3C3, 1500, 0);
        send(0, FRAME - 1, 1'b0);
        build(12'h0F0, 1500, 0);
        send(0, FRAME, 1'b0);
        idle(4);

        build(12'h123, 2047, 0);
        send(0, FRAME, 1'b0);
        build(12'hFED, 2047, 0);
        send(0, FRAME, 1'b0);
        idle(4);

        build(12'h9B1, 2047, 0);
        send(0, 2000, 1'b0);
        @(negedge clk);
        en   = 1'b0;
        arst = 1'b1;
        inframe = 1'b0;
        #1;
        check_outputs_zero("arst");
        @(negedge clk);
        arst = 1'b0;
        send(2000, FRAME - 2000, 1'b0);
        idle(4);

        build(12'h0F3, 2047, 0);
        send(0, FRAME, 1'b0);
        idle(4);

        for (int r = 0; r < 3; r++) begin
            w = DW'($urandom);
            build(w, int'($urandom_range(20, 2000)), int'($urandom_range(0, 300)));
            send(0, FRAME, 1'b0);
            idle(int'($urandom_range(1, 6)));
        end

        idle(10);
        check("dv_outstanding", exp_q.size(), 0);
        check("err_outstanding", err_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bpsk_demodulator.md
# bpsk_demodulator

Coherent BPSK receiver that takes the modulator's 12-bit sample stream and recovers each Hamming codeword, for the hamming_decoder that follows. Each code bit occupies one carrier period of SAMPLE_NUMBER samples. The block correlates each period against the sign of the local carrier, decides the bit from the sign of the correlation, and assembles DATA_WIDTH bits MSB-first. It outputs the codeword with a one-cycle valid strobe.

## Interface
- SAMPLE_NUMBER, 256: samples per carrier period (one code bit); power of two, ≥4.
- SAMPLE_WIDTH, 12: sample width, two's complement.
- DATA_WIDTH, 12: codeword bits per frame.
- THRESHOLD, 4096: minimum |correlation| for a confident bit decision (unsigned).
- clk  in  1  system clock.
- arst  in  1  reset, asynchronous, active-high.
- en  in  1  sample qualifier; `sample` and `sof` are consumed only when en=1.
- sof  in  1  start of frame; marks the qualified sample that is sample 0 of bit DATA_WIDTH-1.
- sample  in  SAMPLE_WIDTH  signed received sample.
- q  out  DATA_WIDTH  recovered codeword; bit DATA_WIDTH-1 is the first bit received.
- dv  out  1  one-cycle pulse when q is updated.
- low_conf  out  1  valid with dv; 1 if any bit in the frame had |acc| < THRESHOLD.
- err  out  1  one-cycle pulse when sof arrives mid-frame.

## Operation
- Carrier convention: bit 1 = +sin, bit 0 = −sin, one full period per bit. The phase index k runs 0..SAMPLE_NUMBER-1.
- Correlation per bit: acc += sample when k < SAMPLE_NUMBER/2; acc −= sample otherwise.
- acc is signed, SAMPLE_WIDTH+log2(SAMPLE_NUMBER)+1 bits (21 at defaults). It never overflows.
- Bit decision: acc > 0 → 1; acc ≤ 0 → 0.
- The low-confidence flag is set if |acc| < THRESHOLD.
- After each decision, acc is cleared, so the next bit starts from 0.
- States:
  - IDLE: waits for en&sof. That sample is taken as k=0 of the first bit; go to ACQ.
  - ACQ: each en cycle advances k. At k wrap, the bit is shifted into the shift register (MSB-first) and the bit counter increments.
  - ACQ to IDLE: after the final sample of bit 0, go to IDLE. The same cycle registers q and low_conf and raises dv on the next edge.
- en=0 holds all state: k, bit counter and acc are frozen.
- sof outside IDLE: counts as a mid-frame sof only when en=1.
  - Abort the current frame and pulse err.
  - Restart with that sample as k=0 of a new frame.
  - No dv is produced for the aborted frame.
- sof on the final sample of a frame is also an abort/restart; that frame's dv is suppressed.
- sof with en=0 is ignored.
- q and low_conf hold their values until the next dv.

## Timing
- Reset values: q=0, dv=0, low_conf=0, err=0. State IDLE, k=0, bit counter=0, acc=0.
- arst mid-frame discards the partial frame immediately. The block then needs a fresh sof.
- Latency: dv is high in the cycle after the clk edge that consumes qualified sample SAMPLE_NUMBER·DATA_WIDTH−1 (3071 at defaults).
- err is high in the cycle after the offending sof is consumed.
- dv and err are never high together.
- Continuous frames are supported: a sof in the cycle following the final sample (already in IDLE) starts the next frame with no lost samples.
- Throughput: one sample per clk. No backpressure; the downstream stage must accept dv pulses as they come.

## Structure
- Shared package bpsk_pkg: defaults for SAMPLE_NUMBER, SAMPLE_WIDTH and DATA_WIDTH (shared with bpsk_modulator), the accumulator width function, and the state enum (IDLE, ACQ).
- Sub-module bpsk_correlator: the integrate-and-dump datapath.
  - Inputs: clk, arst, en, clear, sample.
  - Outputs: bit, weak, done at k wrap.
- The top level holds the FSM, the bit counter, the shift register and the output registers.

## Test plan
- Ideal frame: sample = round(2047·sin(2πk/256)) with sign per bit of 12'hA5C, en=1, sof on the first sample → q=12'hA5C, low_conf=0, and exactly one dv, 1 cycle after sample 3071.
- Gapped en: same frame with en toggling 1/0 every cycle, and sample/sof held during en=0 → q=12'hA5C, dv 1 cycle after the 3072nd qualified sample.
- Noise: 12'h3F0 frame at amplitude 1000 plus uniform ±600 noise → q=12'h3F0, low_conf=0.
- All-zero samples for a full frame → q=12'h000, low_conf=1.
- Mid-frame sof after 1000 samples of a 12'h555 frame, then a full 12'hAAA frame → err pulses once, 1 cycle after the second sof; a single dv with q=12'hAAA.
- Reset: arst pulsed after 2000 samples of a frame → outputs 0 immediately; no dv from the remaining samples; the next sof-started frame 12'h0F3 decodes correctly.
- Back-to-back: 12'h123 then 12'hFED with no idle sample between them → two dv pulses exactly 3072 cycles apart with the correct q values.
